// File: rtl/iob_ram_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : iob_ram_rd_streamer
//  Description : Read-side engine for one port of a dual-port RAM. Walks a
//                contiguous (wrapping) address range, absorbs the RAM's
//                one-cycle read latency and presents the words as a
//                valid/ready stream with a last-beat flag. A 2-entry output
//                buffer gives full throughput with lossless backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_ram_rd_streamer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam logic [ADDR_W-1:0] c_addrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_cntOne  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_cntZero = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issueCnt;
    logic [ADDR_W:0]   r_beatCnt;
    logic              r_busy;
    logic              r_done;

    // Read-return tracking and the 2-entry output buffer
    logic              r_inflight;
    logic [DATA_W-1:0] r_fifo0;
    logic [DATA_W-1:0] r_fifo1;
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_count;

    logic              w_pop;
    logic              w_issue;
    logic              w_lastIssue;
    logic              w_lastBeat;
    logic [2:0]        w_occupancy;
    logic [2:0]        w_limit;

    // A read may issue only if, after this cycle's pop, the buffer plus the
    // word already in flight leaves room for it; this makes overflow impossible.
    assign w_pop       = m_valid & m_ready;
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_limit     = 3'd2 + {2'b00, w_pop};
    assign w_issue     = (r_state == ISSUE) && (w_occupancy < w_limit);
    assign w_lastIssue = w_issue && (r_issueCnt == (r_len - c_cntOne));
    assign w_lastBeat  = w_pop && m_last;

    assign ram_en   = w_issue;
    assign ram_we   = 1'b0;
    assign ram_addr = r_addr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign m_valid  = (r_count != 2'd0);
    assign m_data   = r_rdPtr ? r_fifo1 : r_fifo0;
    assign m_last   = m_valid && (r_beatCnt == (r_len - c_cntOne));

    // Control FSM: transfer sequencing, address/word/beat counters, busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_issueCnt <= '0;
            r_beatCnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr     <= start_addr;
                        r_len      <= len;
                        r_issueCnt <= '0;
                        r_beatCnt  <= '0;
                        if (len != c_cntZero) begin
                            r_state <= ISSUE;
                            r_busy  <= 1'b1;
                        end else begin
                            // Empty transfer completes without touching the RAM
                            r_done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_addr     <= r_addr + c_addrOne;
                        r_issueCnt <= r_issueCnt + c_cntOne;
                        if (w_lastIssue) begin
                            r_state <= DRAIN;
                        end
                    end
                    if (w_pop) begin
                        r_beatCnt <= r_beatCnt + c_cntOne;
                    end
                end
                DRAIN: begin
                    if (w_pop) begin
                        r_beatCnt <= r_beatCnt + c_cntOne;
                    end
                    if (w_lastBeat) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: capture RAM data the cycle after a read into the output buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_fifo0    <= '0;
            r_fifo1    <= '0;
            r_wrPtr    <= 1'b0;
            r_rdPtr    <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            if (r_inflight) begin
                if (r_wrPtr) begin
                    r_fifo1 <= ram_dout;
                end else begin
                    r_fifo0 <= ram_dout;
                end
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire
